// File: rtl/haar_pkg.sv
// Shared window geometry, derived address width and builder FSM encoding
// for the integral-image path.
package haar_pkg;

  localparam int WIN_W = 20;
  localparam int WIN_H = 20;
  localparam int PIX_W = 8;
  localparam int II_W  = 32;
  localparam int II_AW = $clog2((WIN_W + 1) * (WIN_H + 1));

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ZROW = 3'd1,
    ZCOL = 3'd2,
    PIX  = 3'd3,
    DONE = 3'd4
  } ii_state_e;

endpackage

// File: rtl/ii_line_buf.sv
// Column-running-sum line buffer: one combinational read port and one write
// port per cycle, with a whole-buffer clear used when a new window starts.
module ii_line_buf
  import haar_pkg::*;
#(
  parameter int DEPTH = WIN_W + 1,
  parameter int DW    = II_W,
  parameter int AW    = $clog2(WIN_W + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [DW-1:0] rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i
);

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  logic [DW-1:0] mem_r [DEPTH];

  // storage: async reset and start-of-window clear zero every entry
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (wr_en_i && (wr_addr_i <= LAST_IDX)) begin
      mem_r[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_addr_i <= LAST_IDX) ? mem_r[rd_addr_i] : '0;

endmodule

// File: rtl/integral_image_builder.sv
// Streams a raster-order pixel window in and writes its zero-padded integral
// image out one word per cycle, also accumulating sum and sum-of-squares.
module integral_image_builder
  import haar_pkg::*;
#(
  parameter int WIN_W = haar_pkg::WIN_W,
  parameter int WIN_H = haar_pkg::WIN_H,
  parameter int PIX_W = haar_pkg::PIX_W,
  parameter int II_W  = haar_pkg::II_W
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      start_i,
  input  logic [PIX_W-1:0]                          pix_data_i,
  input  logic                                      pix_valid_i,
  output logic                                      pix_ready_o,
  output logic [$clog2((WIN_W+1)*(WIN_H+1))-1:0]    ii_addr_wr_o,
  output logic [II_W-1:0]                           ii_data_wr_o,
  output logic                                      ii_val_wr_o,
  output logic [II_W-1:0]                           sum_o,
  output logic [II_W-1:0]                           sqsum_o,
  output logic                                      busy_o,
  output logic                                      done_o
);

  localparam int AW = $clog2((WIN_W + 1) * (WIN_H + 1));
  localparam int XW = $clog2(WIN_W + 1);
  localparam int YW = $clog2(WIN_H + 1);
  localparam logic [XW-1:0] X_LAST = XW'(WIN_W);
  localparam logic [YW-1:0] Y_LAST = YW'(WIN_H);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [AW-1:0] A_ONE  = AW'(1);

  ii_state_e       state_r, state_s;
  logic [XW-1:0]   x_r, x_s;
  logic [YW-1:0]   y_r, y_s;
  logic [AW-1:0]   addr_r, addr_s;
  logic [II_W-1:0] rowsum_r, rowsum_s, sum_r, sum_s, sqsum_r, sqsum_s;
  logic            act_s, lb_clr_s, lb_we_s, accept_s;
  logic [AW-1:0]   act_addr_s;
  logic [II_W-1:0] act_data_s, lb_rd_s, pix_ext_s, pix_sq_s, ii_s;
  logic            wr_val_r, done_r, busy_r, ready_r;
  logic [AW-1:0]   wr_addr_r;
  logic [II_W-1:0] wr_data_r;

  ii_line_buf #(.DEPTH(WIN_W + 1), .DW(II_W), .AW(XW)) u_line_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (lb_clr_s),
    .rd_addr_i (x_r),
    .rd_data_o (lb_rd_s),
    .wr_en_i   (lb_we_s),
    .wr_addr_i (x_r),
    .wr_data_i (ii_s)
  );

  assign pix_ext_s = II_W'(pix_data_i);
  assign pix_sq_s  = pix_ext_s * pix_ext_s;
  assign ii_s      = lb_rd_s + rowsum_r + pix_ext_s;
  assign accept_s  = ready_r & pix_valid_i;

  // next-state and per-cycle write action; the address counter tracks y*(WIN_W+1)+x
  always_comb begin
    state_s    = state_r;
    x_s        = x_r;
    y_s        = y_r;
    addr_s     = addr_r;
    rowsum_s   = rowsum_r;
    sum_s      = sum_r;
    sqsum_s    = sqsum_r;
    act_s      = 1'b0;
    act_addr_s = addr_r;
    act_data_s = '0;
    lb_clr_s   = 1'b0;
    lb_we_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          // the address-0 zero goes out on the start cycle so the write
          // stream begins immediately; ZROW then covers x = 1..WIN_W
          state_s    = ZROW;
          x_s        = X_ONE;
          y_s        = '0;
          addr_s     = A_ONE;
          rowsum_s   = '0;
          sum_s      = '0;
          sqsum_s    = '0;
          lb_clr_s   = 1'b1;
          act_s      = 1'b1;
          act_addr_s = '0;
        end else begin
          state_s = IDLE;
        end
      end
      ZROW: begin
        act_s  = 1'b1;
        addr_s = addr_r + A_ONE;
        if (x_r == X_LAST) begin
          state_s = ZCOL;
          y_s     = Y_ONE;
        end else begin
          x_s = x_r + X_ONE;
        end
      end
      ZCOL: begin
        act_s    = 1'b1;
        addr_s   = addr_r + A_ONE;
        rowsum_s = '0;
        x_s      = X_ONE;
        state_s  = PIX;
      end
      PIX: begin
        if (accept_s) begin
          act_s      = 1'b1;
          act_data_s = ii_s;
          lb_we_s    = 1'b1;
          addr_s     = addr_r + A_ONE;
          rowsum_s   = rowsum_r + pix_ext_s;
          sum_s      = sum_r + pix_ext_s;
          sqsum_s    = sqsum_r + pix_sq_s;
          if (x_r != X_LAST) begin
            x_s = x_r + X_ONE;
          end else if (y_r == Y_LAST) begin
            state_s = DONE;
          end else begin
            y_s     = y_r + Y_ONE;
            state_s = ZCOL;
          end
        end else begin
          state_s = PIX;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, counters and accumulators
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r  <= IDLE;
      x_r      <= '0;
      y_r      <= '0;
      addr_r   <= '0;
      rowsum_r <= '0;
      sum_r    <= '0;
      sqsum_r  <= '0;
    end else begin
      state_r  <= state_s;
      x_r      <= x_s;
      y_r      <= y_s;
      addr_r   <= addr_s;
      rowsum_r <= rowsum_s;
      sum_r    <= sum_s;
      sqsum_r  <= sqsum_s;
    end
  end

  // registered write port and status outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_val_r  <= 1'b0;
      wr_addr_r <= '0;
      wr_data_r <= '0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b0;
    end else begin
      wr_val_r  <= act_s;
      wr_addr_r <= act_s ? act_addr_s : '0;
      wr_data_r <= act_data_s;
      done_r    <= (state_r == DONE);
      busy_r    <= (state_s != IDLE);
      ready_r   <= (state_s == PIX);
    end
  end

  assign ii_val_wr_o  = wr_val_r;
  assign ii_addr_wr_o = wr_addr_r;
  assign ii_data_wr_o = wr_data_r;
  assign done_o       = done_r;
  assign busy_o       = busy_r;
  assign pix_ready_o  = ready_r;
  assign sum_o        = sum_r;
  assign sqsum_o      = sqsum_r;

endmodule

// File: tb/tb_integral_image_builder.sv
// Randomised scoreboard bench for integral_image_builder: expected writes and
// sums come from a direct summation model of the pixel window.
module tb_integral_image_builder;

  localparam int W   = 20;
  localparam int H   = 20;
  localparam int PW  = 8;
  localparam int IW  = 32;
  localparam int AW  = $clog2((W + 1) * (H + 1));
  localparam int NWR = (W + 1) * (H + 1);

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [PW-1:0] pix_data_i = '0;
  logic          pix_valid_i = 1'b0;
  logic          pix_ready_o;
  logic [AW-1:0] ii_addr_wr_o;
  logic [IW-1:0] ii_data_wr_o;
  logic          ii_val_wr_o;
  logic [IW-1:0] sum_o;
  logic [IW-1:0] sqsum_o;
  logic          busy_o;
  logic          done_o;

  integral_image_builder #(.WIN_W(W), .WIN_H(H), .PIX_W(PW), .II_W(IW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .pix_data_i(pix_data_i), .pix_valid_i(pix_valid_i), .pix_ready_o(pix_ready_o),
    .ii_addr_wr_o(ii_addr_wr_o), .ii_data_wr_o(ii_data_wr_o), .ii_val_wr_o(ii_val_wr_o),
    .sum_o(sum_o), .sqsum_o(sqsum_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int     addr;
    longint data;
  } wr_t;

  wr_t    exp_q[$];
  longint sum_q[$];
  longint sq_q[$];
  int     pix[0:H][0:W];
  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  int     wr_cnt = 0;
  int     first_wr = 0;
  int     last_wr = 0;
  int     done_cyc = 0;
  int     done_cnt = 0;
  longint last_data = 0;
  bit     prev_valid = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk_i);
    cyc++;
  end

  // monitor: pops the scoreboard whenever the DUT writes or signals done
  initial forever begin
    @(negedge clk_i);
    if (rst_i) begin
      if (ii_val_wr_o) begin
        if (wr_cnt == 0) first_wr = cyc;
        last_wr   = cyc;
        last_data = longint'(ii_data_wr_o);
        wr_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr %0d expected no write", ii_addr_wr_o);
        end else begin
          wr_t e;
          int  a;
          e = exp_q.pop_front();
          check("wr_addr", ii_addr_wr_o, e.addr);
          check("wr_data", ii_data_wr_o, e.data);
          a = int'(ii_addr_wr_o);
          if ((a % (W + 1)) != 0 && (a / (W + 1)) != 0) check("wr_needs_valid", prev_valid, 1);
        end
      end
      if (done_o) begin
        done_cyc = cyc;
        done_cnt++;
        if (sum_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done pulse expected none");
        end else begin
          check("sum_o", sum_o, sum_q.pop_front());
          check("sqsum_o", sqsum_o, sq_q.pop_front());
        end
      end
    end
    prev_valid = pix_valid_i;
  end

  // pmode: 0 ones, 1 all 255, 2 (r+c)%256, 3 random; vmode: 0 held, 1 toggled, 2 random
  task automatic run_build(input int pmode, input int vmode, input int abort_at,
                           output longint exp_sum, output longint exp_sq);
    int  idx, n, d0, start_cyc;
    bit  acc, aborted;
    for (int r = 1; r <= H; r++)
      for (int c = 1; c <= W; c++)
        case (pmode)
          0: pix[r][c] = 1;
          1: pix[r][c] = 255;
          2: pix[r][c] = (r + c) % 256;
          default: pix[r][c] = int'($urandom_range(0, 255));
        endcase
    exp_sum = 0;
    exp_sq  = 0;
    for (int y = 0; y <= H; y++)
      for (int x = 0; x <= W; x++) begin
        wr_t e;
        e.addr = y * (W + 1) + x;
        e.data = 0;
        for (int r = 1; r <= y; r++)
          for (int c = 1; c <= x; c++) e.data += pix[r][c];
        exp_q.push_back(e);
      end
    for (int r = 1; r <= H; r++)
      for (int c = 1; c <= W; c++) begin
        exp_sum += pix[r][c];
        exp_sq  += pix[r][c] * pix[r][c];
      end
    sum_q.push_back(exp_sum);
    sq_q.push_back(exp_sq);
    wr_cnt = 0;
    d0 = done_cnt;
    idx = 0;
    n = 0;
    aborted = 1'b0;
    @(posedge clk_i);
    #1;
    start_cyc = cyc;
    while (done_cnt == d0 && n < 3000 && !aborted) begin
      start_i = (n == 0) || (vmode == 1 && n == 150);
      case (vmode)
        0: pix_valid_i = (idx < W * H);
        1: pix_valid_i = (idx < W * H) && (n % 2 == 0);
        default: pix_valid_i = (idx < W * H) && ($urandom_range(0, 3) != 0);
      endcase
      pix_data_i = (idx < W * H) ? PW'(pix[idx / W + 1][idx % W + 1]) : '0;
      @(negedge clk_i);
      acc = pix_valid_i && pix_ready_o;
      #1;
      if (abort_at > 0 && wr_cnt >= abort_at) begin
        rst_i = 1'b0;
        #1;
        check("reset_outputs_zero",
              |{pix_ready_o, ii_addr_wr_o, ii_data_wr_o, ii_val_wr_o, sum_o, sqsum_o, busy_o, done_o},
              0);
        exp_q.delete();
        sum_q.delete();
        sq_q.delete();
        start_i = 1'b0;
        pix_valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        aborted = 1'b1;
      end else begin
        @(posedge clk_i);
        #1;
        if (acc) idx++;
        n++;
      end
    end
    start_i = 1'b0;
    pix_valid_i = 1'b0;
    if (aborted) begin
      repeat (5) @(negedge clk_i);
      check("no_done_after_abort", done_cnt, d0);
      check("abort_write_count", wr_cnt, abort_at);
    end else begin
      check("done_seen", done_cnt, d0 + 1);
      check("scoreboard_drained", exp_q.size(), 0);
      check("write_count", wr_cnt, NWR);
      if (vmode == 0) begin
        check("first_write_cycle", first_wr - start_cyc, 1);
        check("last_write_cycle", last_wr - start_cyc, NWR);
        check("done_cycle", done_cyc - start_cyc, NWR + 1);
      end
      @(negedge clk_i);
      check("done_one_cycle", done_o, 0);
      check("busy_after_done", busy_o, 0);
      check("sum_hold", sum_o, exp_sum);
      check("sqsum_hold", sqsum_o, exp_sq);
    end
  endtask

  initial begin
    longint s, q;
    repeat (3) @(negedge clk_i);
    check("reset_state",
          |{pix_ready_o, ii_addr_wr_o, ii_data_wr_o, ii_val_wr_o, sum_o, sqsum_o, busy_o, done_o}, 0);
    rst_i = 1'b1;
    repeat (2) @(negedge clk_i);

    run_build(0, 0, 0, s, q);
    check("ones_sum", sum_o, 400);
    check("ones_sqsum", sqsum_o, 400);
    check("ones_ii_20_20", last_data, 400);

    run_build(1, 0, 0, s, q);
    check("max_sum", sum_o, 102000);
    check("max_sqsum", sqsum_o, 26010000);
    check("max_ii_20_20", last_data, 102000);

    run_build(2, 1, 0, s, q);
    run_build(3, 2, 200, s, q);
    run_build(3, 0, 0, s, q);
    run_build(3, 2, 0, s, q);

    repeat (3) @(negedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/integral_image_builder.md
INTEGRAL_IMAGE_BUILDER -- requirements
Module: integral_image_builder

Interface
REQ-001 The block SHALL have parameter WIN_W, default 20, meaning window width in pixels.
REQ-002 The block SHALL have parameter WIN_H, default 20, meaning window height in pixels.
REQ-003 The block SHALL have parameter PIX_W, default 8, meaning pixel width (unsigned).
REQ-004 The block SHALL have parameter II_W, default 32, meaning integral-image word width.
REQ-005 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all logic is clocked on its rising edge.
REQ-006 The block SHALL have port rst_i, input, 1 bit, meaning reset, asynchronous and active-low.
REQ-007 The block SHALL have port start_i, input, 1 bit, meaning a one-cycle request to build a new window.
REQ-008 The block SHALL have port pix_data_i, input, PIX_W bits, meaning pixel data in raster order.
REQ-009 The block SHALL have port pix_valid_i, input, 1 bit, meaning pix_data_i is valid.
REQ-010 The block SHALL have port pix_ready_o, output, 1 bit, meaning the block accepts a pixel this cycle.
REQ-011 The block SHALL have port ii_addr_wr_o, output, $clog2((WIN_W+1)*(WIN_H+1)) bits, meaning the integral-image write address.
REQ-012 The block SHALL have port ii_data_wr_o, output, II_W bits, meaning the integral-image write data.
REQ-013 The block SHALL have port ii_val_wr_o, output, 1 bit, meaning the write strobe.
REQ-014 The block SHALL have port sum_o, output, II_W bits, meaning the sum of window pixels.
REQ-015 The block SHALL have port sqsum_o, output, II_W bits, meaning the sum of squared window pixels.
REQ-016 The block SHALL have port busy_o, output, 1 bit, meaning a build is in progress.
REQ-017 The block SHALL have port done_o, output, 1 bit, meaning a one-cycle pulse when the image, sum_o and sqsum_o are complete; it drives the cascade's start_i.

Function
REQ-018 Written image SHALL be (WIN_W+1)x(WIN_H+1), address = y*(WIN_W+1)+x; row 0 and column 0 all zero; ii(y,x)=sum of pixels p(r,c), 1<=r<=y, 1<=c<=x.
REQ-019 FSM states SHALL be IDLE, ZROW, ZCOL, PIX, DONE.
REQ-020 IDLE with start_i=1 SHALL go to ZROW and clear the line buffer, sum, sqsum, x and y; start_i outside IDLE SHALL be ignored.
REQ-021 ZROW SHALL write zero to addresses 0..WIN_W, one per cycle, then go to ZCOL with y=1.
REQ-022 ZCOL SHALL write zero to address y*(WIN_W+1), clear rowsum and go to PIX with x=1.
REQ-023 pix_ready_o SHALL be 1 only in PIX; a pixel is accepted when pix_valid_i and pix_ready_o are both 1; with no acceptance the state holds and ii_val_wr_o=0.
REQ-024 On acceptance the block SHALL set rowsum+=p, ii=line[x]+rowsum, line[x]<=ii, sum+=p, sqsum+=p*p, and write ii to address y*(WIN_W+1)+x.
REQ-025 After x=WIN_W, PIX SHALL go to ZCOL (y+1), or to DONE when y=WIN_H.
REQ-026 DONE SHALL assert done_o for one cycle and return to IDLE.
REQ-027 Write outputs SHALL be registered, asserted the cycle after the action; addresses SHALL be strictly ascending 0..(WIN_W+1)(WIN_H+1)-1 with no gaps.
REQ-028 Throughput: with pix_valid_i held 1, ii_val_wr_o SHALL be high for 441 consecutive cycles starting the cycle after start_i, and done_o SHALL pulse the cycle after the last write.
REQ-029 sum_o and sqsum_o SHALL be registered, stable from done_o until the next start, and unsigned zero-extended; defaults need 17 and 25 bits, so no overflow occurs.
REQ-030 busy_o SHALL be 1 in every state except IDLE.

Reset
REQ-031 rst_i=0 SHALL at any time, including mid-build, force IDLE and zero every output, counter, accumulator and line-buffer entry; no done_o pulse is issued for an aborted build.

Structure
REQ-032 WIN_W, WIN_H, PIX_W, II_W, the derived address width and the FSM state enum SHALL live in shared package haar_pkg.
REQ-033 The (WIN_W+1)-entry line buffer SHALL be a sub-module ii_line_buf with one read and one write port per cycle.

Verification
REQ-034 All pixels 1, valid held -> 441 writes; ii(y,x)=x*y; ii(20,20)=400; sum_o=400; sqsum_o=400; done_o at cycle 442.
REQ-035 All pixels 255 -> sum_o=102000, sqsum_o=26010000, ii(20,20)=102000.
REQ-036 Pixel p(r,c)=(r+c)%256, valid toggled every other cycle -> writes match the reference model; no write while pix_valid_i=0; addresses still contiguous.
REQ-037 start_i pulsed mid-build -> ignored; a start after done_o -> a second correct build with sums reset.
REQ-038 rst_i=0 asserted at write 200 -> all outputs 0 the same cycle; a new start then yields the correct full image.
